// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: register file read, EX/MEM and writeback bypass, load-use stall, ID/EX register
module operand_fetch_stage #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int CTRLW = 16,
  parameter int CNTW  = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [XLEN-1:0]  IN_PC,
  input  logic [AW-1:0]    IN_RS1,
  input  logic [AW-1:0]    IN_RS2,
  input  logic [AW-1:0]    IN_RD,
  input  logic             IN_USES_RS1,
  input  logic             IN_USES_RS2,
  input  logic             IN_REG_WRITE,
  input  logic             IN_IS_LOAD,
  input  logic [CTRLW-1:0] IN_CTRL,
  output logic [AW-1:0]    RF_OUT1ADDRESS,
  output logic [AW-1:0]    RF_OUT2ADDRESS,
  input  logic [XLEN-1:0]  RF_OUT1,
  input  logic [XLEN-1:0]  RF_OUT2,
  input  logic             EXM_WRITE,
  input  logic             EXM_IS_LOAD,
  input  logic [AW-1:0]    EXM_RD,
  input  logic [XLEN-1:0]  EXM_DATA,
  input  logic             WB_WRITE,
  input  logic [AW-1:0]    WB_ADDR,
  input  logic [XLEN-1:0]  WB_DATA,
  input  logic             FLUSH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  OUT_PC,
  output logic [XLEN-1:0]  OUT_OP1,
  output logic [XLEN-1:0]  OUT_OP2,
  output logic [AW-1:0]    OUT_RD,
  output logic             OUT_REG_WRITE,
  output logic             OUT_IS_LOAD,
  output logic [CTRLW-1:0] OUT_CTRL,
  output logic             HAZ_STALL,
  output logic [CNTW-1:0]  STALL_COUNT
);
  logic            load_en;
  logic            dep1;
  logic            dep2;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  // Bypass priority: x0, then a non-load EX/MEM result, then the write landing in the file this edge.
  function automatic logic [XLEN-1:0] resolve(input logic [AW-1:0] rs, input logic [XLEN-1:0] rf,
                                              input logic ew, input logic el, input logic [AW-1:0] erd,
                                              input logic [XLEN-1:0] ed, input logic ww,
                                              input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
    return rs == '0 ? '0 : (ew && !el && erd == rs) ? ed : (ww && wa == rs) ? wd : rf;
  endfunction

  // A source depends on a load whose data is not yet available (in ID/EX or in EX/MEM).
  function automatic logic load_dep(input logic [AW-1:0] rs, input logic ov, input logic ol,
                                    input logic orw, input logic [AW-1:0] ord, input logic ew,
                                    input logic el, input logic [AW-1:0] erd);
    return rs != '0 && ((ov && ol && orw && ord == rs) || (ew && el && erd == rs));
  endfunction

  assign RF_OUT1ADDRESS = IN_RS1;
  assign RF_OUT2ADDRESS = IN_RS2;
  assign op1  = resolve(IN_RS1, RF_OUT1, EXM_WRITE, EXM_IS_LOAD, EXM_RD, EXM_DATA, WB_WRITE, WB_ADDR, WB_DATA);
  assign op2  = resolve(IN_RS2, RF_OUT2, EXM_WRITE, EXM_IS_LOAD, EXM_RD, EXM_DATA, WB_WRITE, WB_ADDR, WB_DATA);
  assign dep1 = IN_USES_RS1 && load_dep(IN_RS1, OUT_VALID, OUT_IS_LOAD, OUT_REG_WRITE, OUT_RD, EXM_WRITE, EXM_IS_LOAD, EXM_RD);
  assign dep2 = IN_USES_RS2 && load_dep(IN_RS2, OUT_VALID, OUT_IS_LOAD, OUT_REG_WRITE, OUT_RD, EXM_WRITE, EXM_IS_LOAD, EXM_RD);
  assign HAZ_STALL = IN_VALID && (dep1 || dep2);
  assign load_en   = !OUT_VALID || OUT_READY;
  assign IN_READY  = RESET && (FLUSH || (load_en && !HAZ_STALL));

  // ID/EX register: flush kills, backpressure holds, hazard inserts a counted bubble, else capture.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      OUT_VALID     <= 1'b0;
      OUT_PC        <= '0;
      OUT_OP1       <= '0;
      OUT_OP2       <= '0;
      OUT_RD        <= '0;
      OUT_REG_WRITE <= 1'b0;
      OUT_IS_LOAD   <= 1'b0;
      OUT_CTRL      <= '0;
      STALL_COUNT   <= '0;
    end else if (FLUSH) begin
      OUT_VALID <= 1'b0;
    end else if (load_en) begin
      if (HAZ_STALL) begin
        OUT_VALID <= 1'b0;
        if (~&STALL_COUNT) STALL_COUNT <= STALL_COUNT + CNTW'(1);
      end else if (IN_VALID) begin
        OUT_VALID     <= 1'b1;
        OUT_PC        <= IN_PC;
        OUT_OP1       <= op1;
        OUT_OP2       <= op2;
        OUT_RD        <= IN_RD;
        OUT_REG_WRITE <= IN_REG_WRITE;
        OUT_IS_LOAD   <= IN_IS_LOAD;
        OUT_CTRL      <= IN_CTRL;
      end else begin
        OUT_VALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed scenarios plus random traffic checked against a reference model
module tb_operand_fetch_stage;
  localparam int XLEN = 32, AW = 5, CTRLW = 16, CNTW = 4;
  localparam logic [CNTW-1:0] CMAX = '1;

  logic CLK = 0, RESET = 0;
  logic IN_VALID = 0, IN_READY;
  logic [XLEN-1:0] IN_PC = 0;
  logic [AW-1:0] IN_RS1 = 0, IN_RS2 = 0, IN_RD = 0;
  logic IN_USES_RS1 = 0, IN_USES_RS2 = 0, IN_REG_WRITE = 0, IN_IS_LOAD = 0;
  logic [CTRLW-1:0] IN_CTRL = 0;
  logic [AW-1:0] RF_OUT1ADDRESS, RF_OUT2ADDRESS;
  logic [XLEN-1:0] RF_OUT1, RF_OUT2;
  logic EXM_WRITE = 0, EXM_IS_LOAD = 0;
  logic [AW-1:0] EXM_RD = 0;
  logic [XLEN-1:0] EXM_DATA = 0;
  logic WB_WRITE = 0;
  logic [AW-1:0] WB_ADDR = 0;
  logic [XLEN-1:0] WB_DATA = 0;
  logic FLUSH = 0, OUT_VALID, OUT_READY = 1;
  logic [XLEN-1:0] OUT_PC, OUT_OP1, OUT_OP2;
  logic [AW-1:0] OUT_RD;
  logic OUT_REG_WRITE, OUT_IS_LOAD;
  logic [CTRLW-1:0] OUT_CTRL;
  logic HAZ_STALL;
  logic [CNTW-1:0] STALL_COUNT;

  logic [XLEN-1:0] rf_mem [32];
  assign RF_OUT1 = rf_mem[RF_OUT1ADDRESS];
  assign RF_OUT2 = rf_mem[RF_OUT2ADDRESS];

  operand_fetch_stage #(.XLEN(XLEN), .AW(AW), .CTRLW(CTRLW), .CNTW(CNTW)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_PC(IN_PC),
    .IN_RS1(IN_RS1), .IN_RS2(IN_RS2), .IN_RD(IN_RD), .IN_USES_RS1(IN_USES_RS1),
    .IN_USES_RS2(IN_USES_RS2), .IN_REG_WRITE(IN_REG_WRITE), .IN_IS_LOAD(IN_IS_LOAD),
    .IN_CTRL(IN_CTRL), .RF_OUT1ADDRESS(RF_OUT1ADDRESS), .RF_OUT2ADDRESS(RF_OUT2ADDRESS),
    .RF_OUT1(RF_OUT1), .RF_OUT2(RF_OUT2), .EXM_WRITE(EXM_WRITE), .EXM_IS_LOAD(EXM_IS_LOAD),
    .EXM_RD(EXM_RD), .EXM_DATA(EXM_DATA), .WB_WRITE(WB_WRITE), .WB_ADDR(WB_ADDR),
    .WB_DATA(WB_DATA), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_PC(OUT_PC), .OUT_OP1(OUT_OP1), .OUT_OP2(OUT_OP2), .OUT_RD(OUT_RD),
    .OUT_REG_WRITE(OUT_REG_WRITE), .OUT_IS_LOAD(OUT_IS_LOAD), .OUT_CTRL(OUT_CTRL),
    .HAZ_STALL(HAZ_STALL), .STALL_COUNT(STALL_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;
  logic last_haz, last_rdy;

  // Reference contents of the ID/EX slot and the bubble counter.
  typedef struct {
    logic v; logic [XLEN-1:0] pc, op1, op2; logic [AW-1:0] rd;
    logic rw, ld; logic [CTRLW-1:0] ctrl; logic [CNTW-1:0] cnt;
  } slot_t;
  slot_t m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_op(input logic [AW-1:0] rs);
    if (rs == 0) return 0;
    if (EXM_WRITE && !EXM_IS_LOAD && EXM_RD == rs) return EXM_DATA;
    if (WB_WRITE && WB_ADDR == rs) return WB_DATA;
    return rf_mem[rs];
  endfunction

  function automatic logic ref_haz();
    logic [AW-1:0] src [2];
    logic use_s [2];
    logic h;
    src = '{IN_RS1, IN_RS2};
    use_s = '{IN_USES_RS1, IN_USES_RS2};
    h = 0;
    for (int i = 0; i < 2; i++)
      if (use_s[i] && src[i] != 0) begin
        if (m.v && m.ld && m.rw && m.rd == src[i]) h = 1;
        if (EXM_WRITE && EXM_IS_LOAD && EXM_RD == src[i]) h = 1;
      end
    return IN_VALID && h;
  endfunction

  task automatic step();
    slot_t n;
    logic haz, adv;
    #1;
    haz = ref_haz();
    adv = !m.v || OUT_READY;
    last_haz = HAZ_STALL;
    last_rdy = IN_READY;
    chk("haz", HAZ_STALL, haz);
    chk("in_ready", IN_READY, RESET && (FLUSH || (adv && !haz)));
    chk("rf_addr", {RF_OUT1ADDRESS, RF_OUT2ADDRESS}, {IN_RS1, IN_RS2});
    n = m;
    if (!RESET) n = '{default: 0};
    else if (FLUSH) n.v = 0;
    else if (!adv) n = m;
    else if (haz) begin n.v = 0; n.cnt = (m.cnt == CMAX) ? m.cnt : m.cnt + 1; end
    else if (IN_VALID) begin
      n.v = 1; n.pc = IN_PC; n.op1 = ref_op(IN_RS1); n.op2 = ref_op(IN_RS2);
      n.rd = IN_RD; n.rw = IN_REG_WRITE; n.ld = IN_IS_LOAD; n.ctrl = IN_CTRL;
    end else n.v = 0;
    @(posedge CLK);
    if (WB_WRITE && WB_ADDR != 0) rf_mem[WB_ADDR] = WB_DATA;
    m = n;
    #1;
    chk("out_valid", OUT_VALID, m.v);
    chk("out_pc", OUT_PC, m.pc);
    chk("out_op1", OUT_OP1, m.op1);
    chk("out_op2", OUT_OP2, m.op2);
    chk("out_rd_flags", {OUT_RD, OUT_REG_WRITE, OUT_IS_LOAD}, {m.rd, m.rw, m.ld});
    chk("out_ctrl", OUT_CTRL, m.ctrl);
    chk("stall_count", STALL_COUNT, m.cnt);
  endtask

  task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                       input logic ld);
    IN_VALID = 1; IN_RS1 = rs1; IN_RS2 = rs2; IN_RD = rd; IN_USES_RS1 = 1; IN_USES_RS2 = 1;
    IN_REG_WRITE = 1; IN_IS_LOAD = ld; IN_PC = $urandom; IN_CTRL = CTRLW'($urandom);
  endtask

  logic [XLEN-1:0] snap_op1;
  logic [XLEN-1:0] snap_pc;

  initial begin
    m = '{default: 0};
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    rf_mem[0] = 0;
    // reset then idle
    step(); step();
    RESET = 1;
    step();
    chk("idle_valid", OUT_VALID, 0);
    chk("idle_count", STALL_COUNT, 0);
    chk("idle_ready", last_rdy, 1);
    // plain read
    rf_mem[5] = 32'h11; rf_mem[6] = 32'h22;
    issue(5, 6, 7, 0);
    step();
    chk("plain_op1", OUT_OP1, 32'h11);
    chk("plain_op2", OUT_OP2, 32'h22);
    chk("plain_rd", OUT_RD, 7);
    chk("plain_valid", OUT_VALID, 1);
    // bypass priority
    EXM_WRITE = 1; EXM_RD = 5; EXM_DATA = 32'hAAAA; WB_WRITE = 1; WB_ADDR = 5; WB_DATA = 32'hBBBB;
    issue(5, 6, 7, 0);
    step();
    chk("byp_exm", OUT_OP1, 32'hAAAA);
    EXM_WRITE = 0;
    step();
    chk("byp_wb", OUT_OP1, 32'hBBBB);
    IN_RS1 = 0;
    step();
    chk("byp_x0", OUT_OP1, 0);
    WB_WRITE = 0;
    // load-use
    issue(1, 2, 3, 1);
    step();
    issue(3, 0, 8, 0);
    step();
    chk("lu_haz1", last_haz, 1);
    chk("lu_bubble1", OUT_VALID, 0);
    EXM_WRITE = 1; EXM_IS_LOAD = 1; EXM_RD = 3; EXM_DATA = 32'hDEAD;
    step();
    chk("lu_haz2", last_haz, 1);
    chk("lu_bubble2", OUT_VALID, 0);
    EXM_WRITE = 0; EXM_IS_LOAD = 0; WB_WRITE = 1; WB_ADDR = 3; WB_DATA = 32'hCAFE;
    step();
    chk("lu_haz3", last_haz, 0);
    chk("lu_op1", OUT_OP1, 32'hCAFE);
    chk("lu_count", STALL_COUNT, 2);
    WB_WRITE = 0;
    // backpressure
    snap_op1 = OUT_OP1; snap_pc = OUT_PC;
    OUT_READY = 0;
    issue(4, 5, 9, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ready", last_rdy, 0);
      chk("bp_op1", OUT_OP1, snap_op1);
      chk("bp_pc", OUT_PC, snap_pc);
      chk("bp_count", STALL_COUNT, 2);
    end
    OUT_READY = 1;
    step();
    // flush
    FLUSH = 1;
    issue(4, 5, 10, 0);
    step();
    chk("fl_ready", last_rdy, 1);
    chk("fl_valid", OUT_VALID, 0);
    FLUSH = 0;
    // reset during a stall
    EXM_WRITE = 1; EXM_IS_LOAD = 1; EXM_RD = 3;
    issue(3, 0, 11, 0);
    step();
    chk("rs_count_pre", STALL_COUNT, 3);
    RESET = 0;
    step();
    chk("rs_haz", last_haz, 1);
    chk("rs_valid", OUT_VALID, 0);
    chk("rs_count", STALL_COUNT, 0);
    RESET = 1;
    // saturation
    for (int i = 0; i < 20; i++) step();
    chk("sat_count", STALL_COUNT, CMAX);
    EXM_WRITE = 0; EXM_IS_LOAD = 0;
    // random traffic
    for (int i = 0; i < 600; i++) begin
      IN_VALID = $urandom_range(0, 3) != 0;
      IN_PC = $urandom; IN_CTRL = CTRLW'($urandom);
      IN_RS1 = AW'($urandom_range(0, 7)); IN_RS2 = AW'($urandom_range(0, 7));
      IN_RD = AW'($urandom_range(0, 7));
      IN_USES_RS1 = $urandom_range(0, 1); IN_USES_RS2 = $urandom_range(0, 1);
      IN_REG_WRITE = $urandom_range(0, 1); IN_IS_LOAD = $urandom_range(0, 2) == 0;
      EXM_WRITE = $urandom_range(0, 1); EXM_IS_LOAD = $urandom_range(0, 2) == 0;
      EXM_RD = AW'($urandom_range(0, 7)); EXM_DATA = $urandom;
      WB_WRITE = $urandom_range(0, 1); WB_ADDR = AW'($urandom_range(0, 7)); WB_DATA = $urandom;
      OUT_READY = $urandom_range(0, 3) != 0;
      FLUSH = $urandom_range(0, 19) == 0;
      RESET = $urandom_range(0, 39) != 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
